// File: rtl/cop_pkg.sv
// cop_pkg: shared widths, the x0 index and the write-back queue entry type.
package cop_pkg;
    localparam int XLEN_DEFAULT = 64;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

    typedef struct packed {
        logic [REG_IDX_W-1:0]    idx;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/cop_wb_fifo.sv
// cop_wb_fifo: circular FIFO storage with wrapping pointers and an occupancy count.
module cop_wb_fifo
    import cop_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   push_entry,
    output entry_t                   mem_o [DEPTH],
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left out of reset; count masks stale data.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign mem_o    = mem_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
endmodule

// File: rtl/cop_wb_queue.sv
// cop_wb_queue: coprocessor result write-back queue with register hazard check.
// Define COP_WB_QUEUE_BYPASS_EN for a zero-latency path from wb_* to rf_* when empty.
module cop_wb_queue
    import cop_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                 cop_clk,
    input  logic                 cop_rst,
    input  logic                 wb_valid,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [REG_IDX_W-1:0] wb_idx,
    output logic                 cop_rdywr,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    input  logic                 rf_ready,
    input  logic [REG_IDX_W-1:0] chk_rs1,
    input  logic [REG_IDX_W-1:0] chk_rs2,
    input  logic [REG_IDX_W-1:0] chk_rs3,
    output logic                 rs_hazard
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic [XLEN-1:0]      data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty, push, pop, byp;

    assign empty     = count == '0;
    assign cop_rdywr = count < CW'(DEPTH);
    assign head      = mem[rd_ptr];

`ifdef COP_WB_QUEUE_BYPASS_EN
    assign byp = empty && wb_valid && wb_idx != X0_IDX && rf_ready;
`else
    assign byp = 1'b0;
`endif

    assign push = wb_valid && cop_rdywr && wb_idx != X0_IDX && !byp;
    assign pop  = !empty && rf_ready;

    cop_wb_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk        (cop_clk),
        .rst        (cop_rst),
        .push       (push),
        .pop        (pop),
        .push_entry ('{idx: wb_idx, data: wb_data}),
        .mem_o      (mem),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count)
    );

    always_comb begin
        rf_we    = !empty || byp;
        rf_waddr = byp ? wb_idx : (empty ? '0 : head.idx);
        rf_wdata = byp ? wb_data : (empty ? '0 : head.data);
    end

    // Slot i is occupied when its distance from the head is below count.
    always_comb begin
        rs_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(PW'(i) - rd_ptr)} < count && mem[i].idx != X0_IDX &&
                (mem[i].idx == chk_rs1 || mem[i].idx == chk_rs2 || mem[i].idx == chk_rs3))
                rs_hazard = 1'b1;
    end
endmodule

// File: tb/tb_cop_wb_queue.sv
// tb_cop_wb_queue: directed checks of the write-back queue, with or without bypass.
module tb_cop_wb_queue;
    logic        clk = 1'b0, rst = 1'b1;
    logic        wb_valid = 1'b0, rf_ready = 1'b0;
    logic [63:0] wb_data = '0;
    logic [4:0]  wb_idx = '0, chk_rs1 = '0, chk_rs2 = '0, chk_rs3 = '0;
    logic        cop_rdywr, rf_we, rs_hazard;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    int          n_chk = 0, n_fail = 0;

    cop_wb_queue dut (
        .cop_clk   (clk),
        .cop_rst   (rst),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_idx    (wb_idx),
        .cop_rdywr (cop_rdywr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_ready  (rf_ready),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rs3   (chk_rs3),
        .rs_hazard (rs_hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] idx, input logic [63:0] data);
        wb_valid = v;
        wb_idx   = idx;
        wb_data  = data;
    endtask

    initial begin
        step();
        check("rst_we", rf_we, 0);
        check("rst_haz", rs_hazard, 0);
        check("rst_rdy", cop_rdywr, 1);
        check("rst_addr", rf_waddr, 0);
        check("rst_data", rf_wdata, 0);
        rst = 1'b0;
        step();

        // single push
        rf_ready = 1'b1;
        drive(1, 5, 64'h1122334455667788);
`ifdef COP_WB_QUEUE_BYPASS_EN
        check("single_byp_we", rf_we, 1);
        check("single_byp_addr", rf_waddr, 5);
        check("single_byp_data", rf_wdata, 64'h1122334455667788);
        step();
        drive(0, 0, 0);
        check("single_byp_after", rf_we, 0);
`else
        check("single_comb_we", rf_we, 0);
        step();
        drive(0, 0, 0);
        check("single_we", rf_we, 1);
        check("single_addr", rf_waddr, 5);
        check("single_data", rf_wdata, 64'h1122334455667788);
        step();
        check("single_drained", rf_we, 0);
`endif

        // fill with the write port stalled, then drain in order
        rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 64'(i) << 8);
            check($sformatf("fill_rdy%0d", i), cop_rdywr, 1);
            step();
        end
        drive(0, 0, 0);
        check("fill_full", cop_rdywr, 0);
        check("fill_head", rf_waddr, 1);
        drive(1, 20, 64'hDEAD);
        step();
        drive(0, 0, 0);
        check("fill_still_full", cop_rdywr, 0);
        check("fill_head_stable", rf_waddr, 1);
        check("fill_data_stable", rf_wdata, 64'h100);
        rf_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_addr%0d", i), rf_waddr, 5'(i));
            check($sformatf("drain_data%0d", i), rf_wdata, 64'(i) << 8);
            step();
        end
        check("drain_empty", rf_we, 0);

        // full with simultaneous pop: push refused this cycle, taken next
        rf_ready = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            drive(1, 5'(i), 64'(i));
            step();
        end
        rf_ready = 1'b1;
        drive(1, 15, 64'hF5);
        check("fp_rdy_low", cop_rdywr, 0);
        check("fp_head", rf_waddr, 11);
        step();
        check("fp_rdy_back", cop_rdywr, 1);
        check("fp_head2", rf_waddr, 12);
        step();
        drive(0, 0, 0);
        check("fp_rdy3", cop_rdywr, 1);
        check("fp_head3", rf_waddr, 13);
        step();
        check("fp_head4", rf_waddr, 14);
        step();
        check("fp_head5", rf_waddr, 15);
        check("fp_data5", rf_wdata, 64'hF5);
        step();
        check("fp_empty", rf_we, 0);

        // x0 results are consumed and dropped
        drive(1, 0, 64'hFF);
        check("x0_comb_we", rf_we, 0);
        check("x0_rdy", cop_rdywr, 1);
        step();
        drive(0, 0, 0);
        check("x0_we1", rf_we, 0);
        step();
        check("x0_we2", rf_we, 0);

        // hazard detection
        rf_ready = 1'b0;
        drive(1, 7, 64'h77);
        step();
        drive(0, 0, 0);
        chk_rs2 = 7;
        #1 check("haz_rs2", rs_hazard, 1);
        chk_rs2 = 0;
        #1 check("haz_zero", rs_hazard, 0);
        chk_rs3 = 7;
        chk_rs1 = 6;
        #1 check("haz_rs3", rs_hazard, 1);
        rf_ready = 1'b1;
        step();
        check("haz_popped", rs_hazard, 0);
        chk_rs1 = 0;
        chk_rs3 = 0;

        // reset mid-operation discards queued entries
        rf_ready = 1'b0;
        drive(1, 3, 64'h33);
        step();
        drive(1, 4, 64'h44);
        step();
        drive(0, 0, 0);
        chk_rs1 = 3;
        check("mid_pre_we", rf_we, 1);
        #2 rst = 1'b1;
        #1 check("mid_we", rf_we, 0);
        check("mid_rdy", cop_rdywr, 1);
        check("mid_addr", rf_waddr, 0);
        check("mid_haz", rs_hazard, 0);
        step();
        rst = 1'b0;
        step();
        check("mid_after_we", rf_we, 0);
        chk_rs1 = 0;

        // bypass latency with an empty queue
        rf_ready = 1'b1;
        drive(1, 9, 64'h99);
`ifdef COP_WB_QUEUE_BYPASS_EN
        check("byp_we", rf_we, 1);
        check("byp_addr", rf_waddr, 9);
        step();
        drive(0, 0, 0);
        check("byp_no_push", rf_we, 0);
`else
        check("nobyp_comb", rf_we, 0);
        step();
        drive(0, 0, 0);
        check("nobyp_we", rf_we, 1);
        check("nobyp_addr", rf_waddr, 9);
        step();
        check("nobyp_drained", rf_we, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
